// File: rtl/fetch.sv
// Instruction fetch stage: requests words from memory with a toggle handshake,
// presents them to decode and redirects the program counter on branches.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        triggerIn,
   input  logic        branchValid,
   input  logic [31:0] branchAddr,
   input  logic [31:0] dataInMem,
   input  logic        triggerInMem,
   output logic [31:0] addrMem,
   output logic        triggerOutMem,
   output logic [31:0] dataOut,
   output logic [31:0] pcOut,
   output logic        readyOut,
   output logic        triggerOut
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} stateType;

   stateType    state, stateNext;
   logic [31:0] pc, pcNext;
   logic [31:0] addrMemNext, dataOutNext, pcOutNext;
   logic        triggerOutMemNext, readyOutNext, triggerOutNext;
   logic        triggerInQ, triggerInMemQ;
   logic        consumeEdge, memEdge;
   logic [31:0] branchTarget;

   assign consumeEdge  = triggerIn != triggerInQ;
   assign memEdge      = triggerInMem != triggerInMemQ;
   assign branchTarget = branchAddr & 32'hFFFF_FFFC;

   // A branch always overrides whatever the current state would otherwise do;
   // a response that belongs to a redirected request is dropped.
   always_comb begin
      stateNext         = state;
      pcNext            = pc;
      addrMemNext       = addrMem;
      triggerOutMemNext = triggerOutMem;
      dataOutNext       = dataOut;
      pcOutNext         = pcOut;
      readyOutNext      = readyOut;
      triggerOutNext    = triggerOut;
      case (state)
         IDLE: stateNext = REQ;
         REQ: begin
            if (branchValid) begin
               pcNext       = branchTarget;
               readyOutNext = 1'b0;
            end else begin
               addrMemNext       = pc;
               triggerOutMemNext = ~triggerOutMem;
               stateNext         = WAIT;
            end
         end
         WAIT: begin
            if (branchValid) begin
               pcNext       = branchTarget;
               readyOutNext = 1'b0;
               stateNext    = memEdge ? REQ : DRAIN;
            end else if (memEdge) begin
               dataOutNext    = dataInMem;
               pcOutNext      = pc;
               readyOutNext   = 1'b1;
               triggerOutNext = ~triggerOut;
               stateNext      = HOLD;
            end
         end
         HOLD: begin
            if (branchValid) begin
               pcNext       = branchTarget;
               readyOutNext = 1'b0;
               stateNext    = REQ;
            end else if (consumeEdge) begin
               pcNext       = pc + 32'd4;
               readyOutNext = 1'b0;
               stateNext    = REQ;
            end
         end
         DRAIN: begin
            if (branchValid) begin
               pcNext       = branchTarget;
               readyOutNext = 1'b0;
            end
            if (memEdge) stateNext = REQ;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Edge-detect copies load the live input levels during reset so that
   // nothing already toggled is mistaken for a new event afterwards.
   always_ff @(posedge clk) begin
      triggerInQ    <= triggerIn;
      triggerInMemQ <= triggerInMem;
      if (reset) begin
         state         <= IDLE;
         pc            <= RESET_PC & 32'hFFFF_FFFC;
         addrMem       <= 32'd0;
         triggerOutMem <= 1'b0;
         dataOut       <= 32'd0;
         pcOut         <= 32'd0;
         readyOut      <= 1'b0;
         triggerOut    <= 1'b0;
      end else begin
         state         <= stateNext;
         pc            <= pcNext;
         addrMem       <= addrMemNext;
         triggerOutMem <= triggerOutMemNext;
         dataOut       <= dataOutNext;
         pcOut         <= pcOutNext;
         readyOut      <= readyOutNext;
         triggerOut    <= triggerOutNext;
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: the bench plays memory and decode, a transaction
// model predicts request addresses and presented instructions.
module tb_fetch;

   logic        clk = 1'b0;
   logic        reset, triggerIn, branchValid, triggerInMem;
   logic [31:0] branchAddr, dataInMem;
   logic [31:0] addrMem, dataOut, pcOut;
   logic        triggerOutMem, readyOut, triggerOut;
   logic [31:0] addrMem2, dataOut2, pcOut2;
   logic        triggerOutMem2, readyOut2, triggerOut2;

   int assertCount = 0;
   int failCount   = 0;

   logic [31:0] reqQ[$];
   logic [31:0] presPcQ[$];
   logic [31:0] presDataQ[$];

   logic [31:0] pcModel;
   logic        trigOutModel, reqLevelSeen;
   logic        outstanding, stale, presented;
   logic        monMemLevel = 1'b0;
   logic        monOutLevel = 1'b0;

   fetch dut (
      .clk(clk), .reset(reset), .triggerIn(triggerIn), .branchValid(branchValid),
      .branchAddr(branchAddr), .dataInMem(dataInMem), .triggerInMem(triggerInMem),
      .addrMem(addrMem), .triggerOutMem(triggerOutMem), .dataOut(dataOut),
      .pcOut(pcOut), .readyOut(readyOut), .triggerOut(triggerOut)
   );

   fetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .reset(reset), .triggerIn(triggerIn), .branchValid(branchValid),
      .branchAddr(branchAddr), .dataInMem(dataInMem), .triggerInMem(triggerInMem),
      .addrMem(addrMem2), .triggerOutMem(triggerOutMem2), .dataOut(dataOut2),
      .pcOut(pcOut2), .readyOut(readyOut2), .triggerOut(triggerOut2)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: every toggle the DUT makes is matched against the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         monMemLevel = triggerOutMem;
         monOutLevel = triggerOut;
      end else begin
         if (triggerOutMem !== monMemLevel) begin
            monMemLevel = triggerOutMem;
            if (reqQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpectedRequest: addrMem=%h, expected no request", addrMem);
            end else begin
               checkOutput("requestAddr", addrMem, reqQ.pop_front());
            end
         end
         if (triggerOut !== monOutLevel) begin
            monOutLevel = triggerOut;
            if (presPcQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpectedPresent: pcOut=%h dataOut=%h, expected no instruction", pcOut, dataOut);
            end else begin
               checkOutput("presentPc", pcOut, presPcQ.pop_front());
               checkOutput("presentData", dataOut, presDataQ.pop_front());
               checkOutput("presentReady", 32'(readyOut), 32'd1);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic consume, input logic branch, input logic [31:0] target,
                                input logic respond, input logic [31:0] data);
      if (consume) triggerIn = ~triggerIn;
      if (respond) begin
         triggerInMem = ~triggerInMem;
         dataInMem    = data;
      end
      branchValid = branch;
      branchAddr  = branch ? target : $urandom;
      cycle();
      branchValid = 1'b0;
      dataInMem   = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic modelReset(input logic [31:0] resetPc);
      reqQ.delete();
      presPcQ.delete();
      presDataQ.delete();
      pcModel      = resetPc;
      trigOutModel = 1'b0;
      reqLevelSeen = 1'b0;
      outstanding  = 1'b0;
      stale        = 1'b0;
      presented    = 1'b0;
   endtask

   task automatic fetchRequest();
      int n;
      n = 0;
      reqQ.push_back(pcModel);
      while (triggerOutMem === reqLevelSeen && n < 12) begin
         cycle();
         n++;
      end
      if (n >= 12) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL requestTimeout: triggerOutMem=%b, expected a new request for %h", triggerOutMem, pcModel);
      end
      reqLevelSeen = triggerOutMem;
      outstanding  = 1'b1;
      stale        = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data, input logic withBranch, input logic [31:0] target);
      logic accept;
      accept = !withBranch && !stale;
      if (accept) begin
         presPcQ.push_back(pcModel);
         presDataQ.push_back(data);
         trigOutModel = ~trigOutModel;
      end
      applyStimulus(1'b0, withBranch, target, 1'b1, data);
      if (withBranch) pcModel = target & 32'hFFFF_FFFC;
      outstanding = 1'b0;
      stale       = 1'b0;
      presented   = accept;
      checkOutput("readyAfterResponse", 32'(readyOut), 32'(accept));
      checkOutput("triggerOutLevel", 32'(triggerOut), 32'(trigOutModel));
   endtask

   task automatic branchTo(input logic [31:0] target);
      applyStimulus(1'b0, 1'b1, target, 1'b0, 32'd0);
      pcModel   = target & 32'hFFFF_FFFC;
      stale     = stale | outstanding;
      presented = 1'b0;
      checkOutput("readyAfterBranch", 32'(readyOut), 32'd0);
   endtask

   task automatic consume(input logic withBranch, input logic [31:0] target);
      applyStimulus(1'b1, withBranch, target, 1'b0, 32'd0);
      pcModel   = withBranch ? (target & 32'hFFFF_FFFC) : pcModel + 32'd4;
      presented = 1'b0;
      checkOutput("readyAfterConsume", 32'(readyOut), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      triggerIn    = 1'b0;
      triggerInMem = 1'b0;
      branchValid  = 1'b0;
      branchAddr   = 32'd0;
      dataInMem    = 32'd0;
      modelReset(32'h0);
      cycle();
      cycle();
      checkOutput("resetReady", 32'(readyOut), 32'd0);
      checkOutput("resetTrigMem", 32'(triggerOutMem), 32'd0);

      // First request appears exactly two cycles after reset falls.
      reset = 1'b0;
      reqQ.push_back(32'h0);
      cycle();
      checkOutput("noEarlyRequest", 32'(triggerOutMem), 32'd0);
      cycle();
      checkOutput("firstReqToggle", 32'(triggerOutMem), 32'd1);
      checkOutput("firstReqAddr", addrMem, 32'h0);
      checkOutput("wrapFirstAddr", addrMem2, 32'hFFFF_FFFC);
      checkOutput("wrapFirstToggle", 32'(triggerOutMem2), 32'd1);
      reqLevelSeen = 1'b1;
      outstanding  = 1'b1;
      idle(5);
      checkOutput("waitHoldsToggle", 32'(triggerOutMem), 32'd1);
      checkOutput("waitNotReady", 32'(readyOut), 32'd0);

      respond(32'hE1A0_00FF, 1'b0, 32'd0);
      checkOutput("wrapPresentPc", pcOut2, 32'hFFFF_FFFC);
      checkOutput("wrapPresentData", dataOut2, 32'hE1A0_00FF);
      checkOutput("wrapPresentReady", 32'(readyOut2), 32'd1);
      checkOutput("wrapPresentTrig", 32'(triggerOut2), 32'd1);
      consume(1'b0, 32'd0);
      fetchRequest();
      checkOutput("secondReqAddr", addrMem, 32'h4);
      checkOutput("wrapSecondAddr", addrMem2, 32'h0);

      // Branch while waiting for memory: the late response is dropped.
      idle(1);
      branchTo(32'h0000_0103);
      idle(2);
      respond(32'hDEAD_BEEF, 1'b0, 32'd0);
      fetchRequest();
      checkOutput("branchRedirectAddr", addrMem, 32'h0000_0100);

      // Consume and branch in the same cycle: branch target wins.
      respond($urandom, 1'b0, 32'd0);
      consume(1'b1, 32'h40);
      fetchRequest();
      checkOutput("branchWinsAddr", addrMem, 32'h40);

      // Reset while holding an instruction, with a stray response at release.
      respond($urandom, 1'b0, 32'd0);
      idle(1);
      reset = 1'b1;
      cycle();
      checkOutput("rstAddrMem", addrMem, 32'd0);
      checkOutput("rstTrigMem", 32'(triggerOutMem), 32'd0);
      checkOutput("rstDataOut", dataOut, 32'd0);
      checkOutput("rstPcOut", pcOut, 32'd0);
      checkOutput("rstReady", 32'(readyOut), 32'd0);
      checkOutput("rstTrigOut", 32'(triggerOut), 32'd0);
      cycle();
      modelReset(32'h0);
      reset        = 1'b0;
      triggerInMem = ~triggerInMem;
      cycle();
      fetchRequest();
      checkOutput("postResetAddr", addrMem, 32'h0);
      checkOutput("postResetTrigOut", 32'(triggerOut), 32'd0);

      for (int it = 0; it < 200; it++) begin
         idle($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0, 1: respond($urandom, 1'b0, 32'd0);
            2: begin
               branchTo($urandom);
               idle($urandom_range(0, 2));
               if ($urandom_range(0, 1) == 1) begin
                  branchTo($urandom);
                  idle($urandom_range(0, 1));
               end
               respond($urandom, 1'b0, 32'd0);
            end
            default: respond($urandom, 1'b1, $urandom);
         endcase
         if (presented) begin
            idle($urandom_range(0, 3));
            case ($urandom_range(0, 2))
               0: consume(1'b0, 32'd0);
               1: branchTo($urandom);
               default: consume(1'b1, $urandom);
            endcase
         end
         repeat ($urandom_range(0, 2)) branchTo($urandom);
         fetchRequest();
      end

      idle(3);
      checkOutput("pendingRequests", 32'(reqQ.size()), 32'd0);
      checkOutput("pendingPresents", 32'(presPcQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
